// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// the {instr, pc} buffer entry and the default PC parameters.
package fetch_pkg;

   localparam int INSTR_W  = 32;
   localparam int OPCODE_W = 7;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } fetch_entry_t;

   // Redirect targets are word aligned by clearing the two low bits.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry {instr, pc} buffer between instruction memory and decode: an
// output register plus one skid slot that catches a response under back-pressure.
module fetch_skid_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         load,
   input  fetch_entry_t load_entry,
   input  logic         ready,
   output logic         valid,
   output fetch_entry_t entry
);

   fetch_entry_t skid;
   logic         skid_valid;
   logic         xfer;

   assign xfer = valid & ready;

   // The fetch FSM never loads while the skid slot is occupied, so a full
   // buffer only has to move the skid entry forward on a transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid      <= 1'b0;
         entry      <= '0;
         skid_valid <= 1'b0;
         skid       <= '0;
      end else if (flush) begin
         valid      <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (xfer) begin
            entry      <= skid;
            skid_valid <= 1'b0;
         end
      end else if (load) begin
         if (!valid || ready) begin
            entry <= load_entry;
            valid <= 1'b1;
         end else begin
            skid       <= load_entry;
            skid_valid <= 1'b1;
         end
      end else if (xfer) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, imem req/rvalid handshake and a
// valid/ready interface to decode. Optional counters under FETCH_PERF_CNT_EN.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   output logic                imem_req_o,
   output logic [31:0]         imem_addr_o,
   input  logic                imem_rvalid_i,
   input  logic [INSTR_W-1:0]  imem_rdata_i,
   input  logic                redirect_i,
   input  logic [31:0]         redirect_pc_i,
   output logic                instr_valid_o,
   input  logic                instr_ready_i,
   output logic [INSTR_W-1:0]  instr_o,
   output logic [31:0]         pc_o,
   output logic [OPCODE_W-1:0] opcode_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         fetch_cnt_o,
   output logic [31:0]         stall_cnt_o
`endif
);

   fetch_state_e state;
   logic [31:0]  pc;
   logic         accept;
   fetch_entry_t in_entry;
   fetch_entry_t out_entry;

   // A response is only kept when it answers the current request and no
   // redirect is squashing it in the same cycle.
   assign accept = (state == REQ) && imem_rvalid_i && !redirect_i;

   assign in_entry.instr = imem_rdata_i;
   assign in_entry.pc    = pc;

   assign imem_addr_o = pc;
   assign instr_o     = out_entry.instr;
   assign pc_o        = out_entry.pc;
   assign opcode_o    = out_entry.instr[OPCODE_W-1:0];

   fetch_skid_buffer u_skid (
      .clk        (clk_i),
      .rst        (rst_i),
      .flush      (redirect_i),
      .load       (accept),
      .load_entry (in_entry),
      .ready      (instr_ready_i),
      .valid      (instr_valid_o),
      .entry      (out_entry)
   );

   // Redirect outranks everything but reset; a request already in flight
   // forces a detour through DRAIN so its late response is thrown away.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         imem_req_o <= 1'b0;
      end else if (redirect_i) begin
         pc <= align_pc(redirect_pc_i);
         case (state)
            IDLE: begin
               state      <= IDLE;
               imem_req_o <= 1'b0;
            end
            REQ: begin
               if (imem_rvalid_i) begin
                  state      <= REQ;
                  imem_req_o <= 1'b1;
               end else begin
                  state      <= DRAIN;
                  imem_req_o <= 1'b0;
               end
            end
            HOLD: begin
               state      <= REQ;
               imem_req_o <= 1'b1;
            end
            DRAIN: begin
               state      <= DRAIN;
               imem_req_o <= 1'b0;
            end
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  state      <= REQ;
                  imem_req_o <= 1'b1;
               end
            end
            REQ: begin
               if (imem_rvalid_i) begin
                  pc <= pc + PC_STEP;
                  if (instr_valid_o && !instr_ready_i) begin
                     state      <= HOLD;
                     imem_req_o <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (instr_ready_i) begin
                  state      <= REQ;
                  imem_req_o <= 1'b1;
               end
            end
            DRAIN: begin
               if (imem_rvalid_i) begin
                  state      <= REQ;
                  imem_req_o <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Wrap-around counters of decode transfers and back-pressure cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (instr_valid_o && instr_ready_i)
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         if (instr_valid_o && !instr_ready_i)
            stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit: delivered responses are
// queued as they are driven and compared when decode accepts them.
module tb_instr_fetch_unit;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [6:0]  opcode_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   int          errors;
   int          checks;
   logic [31:0] exp_pc;
   logic [63:0] sb[$];
   logic [63:0] exp_entry;

   instr_fetch_unit dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .opcode_o      (opcode_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o   (fetch_cnt),
      .stall_cnt_o   (stall_cnt)
`endif
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h0020_8033;
      if (addr == 32'h4) return 32'h0010_0093;
      return {addr[26:2], 7'b0010011};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; a delivered response is queued with the bench's PC.
   task automatic apply_stimulus(input logic rvalid, input logic ready, input logic redirect,
                                 input logic [31:0] rpc, input logic deliver);
      imem_rvalid_i = rvalid;
      imem_rdata_i  = (rvalid && deliver) ? mem_word(exp_pc) : 32'hBAD0_0013;
      instr_ready_i = ready;
      redirect_i    = redirect;
      redirect_pc_i = rpc;
      if (rvalid && deliver) begin
         check_output("req_high", 32'(imem_req_o), 32'd1);
         check_output("req_addr", imem_addr_o, exp_pc);
         sb.push_back({mem_word(exp_pc), exp_pc});
         exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
         sb.delete();
         exp_pc = rpc & ~32'h3;
      end
      @(posedge clk_i);
      #1;
   endtask

   always @(negedge clk_i) begin
      if (!rst_i && instr_valid_o && instr_ready_i) begin
         check_output("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_entry = sb.pop_front();
            check_output("sb_instr", instr_o, exp_entry[63:32]);
            check_output("sb_pc", pc_o, exp_entry[31:0]);
         end
      end
   end

   initial begin
      clk_i = 1'b0; rst_i = 1'b1; start_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = '0;
      errors = 0; checks = 0; exp_pc = 32'h0;

      $display("[TB] reset state");
      repeat (2) begin @(posedge clk_i); #1; end
      check_output("rst_req", 32'(imem_req_o), 32'd0);
      check_output("rst_addr", imem_addr_o, 32'h0);
      check_output("rst_valid", 32'(instr_valid_o), 32'd0);
      check_output("rst_instr", instr_o, 32'h0);
      check_output("rst_pc", pc_o, 32'h0);
      rst_i = 1'b0;
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check_output("idle_rvalid_valid", 32'(instr_valid_o), 32'd0);
      check_output("idle_rvalid_req", 32'(imem_req_o), 32'd0);

      $display("[TB] zero-wait streaming");
      start_i = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      start_i = 1'b0;
      check_output("start_req", 32'(imem_req_o), 32'd1);
      check_output("start_addr", imem_addr_o, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_output("s0_valid", 32'(instr_valid_o), 32'd1);
      check_output("s0_instr", instr_o, 32'h0020_8033);
      check_output("s0_pc", pc_o, 32'h0);
      check_output("s0_opcode", 32'(opcode_o), 32'h33);
      check_output("s0_next_addr", imem_addr_o, 32'h4);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_output("s1_instr", instr_o, 32'h0010_0093);
      check_output("s1_pc", pc_o, 32'h4);
      check_output("s1_opcode", 32'(opcode_o), 32'h13);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check_output("s2_valid_falls", 32'(instr_valid_o), 32'd0);
      check_output("s2_addr", imem_addr_o, 32'h8);

      $display("[TB] reset mid-fetch");
      rst_i = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      sb.delete();
      exp_pc = 32'h0;
      check_output("mid_rst_req", 32'(imem_req_o), 32'd0);
      check_output("mid_rst_addr", imem_addr_o, 32'h0);
      check_output("mid_rst_valid", 32'(instr_valid_o), 32'd0);
      rst_i = 1'b0;
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check_output("late_rvalid_valid", 32'(instr_valid_o), 32'd0);
      check_output("late_rvalid_req", 32'(imem_req_o), 32'd0);

      $display("[TB] back-pressure");
      start_i = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      start_i = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check_output("bp_first_valid", 32'(instr_valid_o), 32'd1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check_output("hold_req", 32'(imem_req_o), 32'd0);
         check_output("hold_instr", instr_o, 32'h0020_8033);
         check_output("hold_pc", pc_o, 32'h0);
         apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check_output("release_instr", instr_o, 32'h0010_0093);
      check_output("release_pc", pc_o, 32'h4);
      check_output("release_req", 32'(imem_req_o), 32'd1);
      check_output("release_addr", imem_addr_o, 32'h8);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check_output("release_drained", 32'(instr_valid_o), 32'd0);

      $display("[TB] redirect with request outstanding");
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
      check_output("drain_req", 32'(imem_req_o), 32'd0);
      check_output("drain_valid", 32'(instr_valid_o), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_output("drain_wait_req", 32'(imem_req_o), 32'd0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check_output("drain_exit_req", 32'(imem_req_o), 32'd1);
      check_output("drain_exit_addr", imem_addr_o, 32'h100);
      check_output("drain_stale_valid", 32'(instr_valid_o), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_output("drain_wait_valid", 32'(instr_valid_o), 32'd0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_output("target_pc", pc_o, 32'h100);
      check_output("target_instr", instr_o, 32'h0000_2013);

      $display("[TB] redirect coincident with rvalid");
      apply_stimulus(1'b1, 1'b0, 1'b1, 32'h2000, 1'b0);
      check_output("coinc_valid", 32'(instr_valid_o), 32'd0);
      check_output("coinc_req", 32'(imem_req_o), 32'd1);
      check_output("coinc_addr", imem_addr_o, 32'h2000);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_output("coinc_pc", pc_o, 32'h2000);

      $display("[TB] pc wrap");
      apply_stimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      check_output("wrap_aligned_addr", imem_addr_o, 32'hFFFF_FFFC);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_output("wrap_next_addr", imem_addr_o, 32'h0);
      check_output("wrap_pc", pc_o, 32'hFFFF_FFFC);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_output("wrap_after_instr", instr_o, 32'h0020_8033);
      check_output("wrap_after_pc", pc_o, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

      $display("[TB] redirect from HOLD and repeated redirect in DRAIN");
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check_output("hold2_req", 32'(imem_req_o), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
      check_output("hold_redir_req", 32'(imem_req_o), 32'd1);
      check_output("hold_redir_addr", imem_addr_o, 32'h40);
      check_output("hold_redir_valid", 32'(instr_valid_o), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
      check_output("drain2_req", 32'(imem_req_o), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h93, 1'b0);
      check_output("drain3_req", 32'(imem_req_o), 32'd0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check_output("drain3_exit_req", 32'(imem_req_o), 32'd1);
      check_output("drain3_exit_addr", imem_addr_o, 32'h90);
      check_output("drain3_valid", 32'(instr_valid_o), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_output("drain3_pc", pc_o, 32'h90);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check_output("final_valid", 32'(instr_valid_o), 32'd0);
      check_output("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the decode/control stage: generates the PC, fetches 32-bit instructions from instruction memory over a req/rvalid handshake, and presents them to decode with a valid/ready handshake.
- Exposes opcode_o (instr_o[6:0]) directly for the control unit's opcode input.
- Provides a 2-entry output buffer so decode back-pressure never loses a memory response; handles branch redirect and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that leaves IDLE and begins fetching.
- imem_req_o  out  1  fetch request, held high until imem_rvalid_i.
- imem_addr_o  out  32  fetch address (= pc), stable while imem_req_o is high.
- imem_rvalid_i  in  1  response valid, arrives ≥1 cycle after the req rise.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  branch/jump redirect, flushes the stage.
- redirect_pc_i  in  32  redirect target; bits [1:0] are forced to 0.
- instr_valid_o  out  1  output buffer holds a valid instruction.
- instr_ready_i  in  1  decode accepts the instruction this cycle.
- instr_o  out  32  instruction word.
- pc_o  out  32  PC of instr_o.
- opcode_o  out  7  instr_o[6:0], combinational.

Behaviour:
- Reset: state=IDLE; pc=RESET_PC; imem_req_o=0; imem_addr_o=RESET_PC; instr_valid_o=0; instr_o=0; pc_o=0; skid buffer empty.
- Reset mid-operation takes full priority and discards any outstanding response. IDLE ignores imem_rvalid_i.
- States:
  - IDLE: start_i -> REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc.
  - HOLD: req=0; output and skid buffers both full.
  - DRAIN: req=0; waiting to discard a stale response.
- REQ + rvalid, when the output buffer is empty or instr_ready_i=1: load {rdata, pc} into the output buffer next edge; pc+=PC_STEP; stay in REQ. The new address appears the next cycle, giving 1 instruction/cycle if memory is zero-wait.
- REQ + rvalid, when the output buffer is full and instr_ready_i=0: load the skid entry; pc+=PC_STEP; -> HOLD.
- HOLD + instr_ready_i: skid -> output buffer; -> REQ.
- Fetch latency: instruction is visible on instr_o the cycle after imem_rvalid_i.
- Handshake:
  - A transfer occurs when instr_valid_o & instr_ready_i.
  - instr_o and pc_o hold stable while valid & !ready.
  - instr_valid_o falls after a transfer if no new data is loaded.
- Redirect (priority over everything except reset):
  - pc<=redirect_pc_i & ~3; output and skid buffers invalidated next edge.
  - From REQ with rvalid in the same cycle: response dropped; -> REQ.
  - From REQ without rvalid (request outstanding): -> DRAIN. In DRAIN, the first rvalid is discarded, then -> REQ. A further redirect in DRAIN updates pc and stays in DRAIN.
  - From HOLD: -> REQ.
  - From IDLE: pc updated; stays IDLE.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- start_i outside IDLE is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both reset to 0 and wrapping:
  - fetch_cnt_o counts accepted transfers to decode.
  - stall_cnt_o counts cycles with instr_valid_o & !instr_ready_i.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, REQ, HOLD, DRAIN};
  - INSTR_W=32, OPCODE_W=7;
  - opcode constants OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011;
  - default RESET_PC and PC_STEP.
- Sub-module fetch_skid_buffer:
  - 2-entry {instr, pc} buffer with valid/ready and a flush input;
  - FSM and PC logic stay in the top.

Test Plan:
- Reset, start_i, zero-wait memory returning 0x00208033 at 0x0, 0x00100093 at 0x4, ready=1 -> instr_o sequence 0x00208033/pc 0, then 0x00100093/pc 4, on consecutive cycles; opcode_o 0x33 then 0x13.
- Hold ready=0 for 5 cycles -> exactly 2 instructions buffered, state HOLD, imem_req_o=0, instr_o stable; release ready -> in-order delivery, fetch resumes at pc 0x8.
- redirect_i with redirect_pc_i=0x103 while a request is outstanding -> DRAIN; stale rvalid discarded; next request address 0x100; instr_valid_o=0 until the 0x100 response arrives.
- Redirect coincident with rvalid -> response dropped; the next-cycle request goes to the redirect target.
- rst_i asserted mid-fetch with a pending response -> IDLE, pc=RESET_PC, instr_valid_o=0, late rvalid ignored.
- pc=0xFFFF_FFFC fetch -> next address 0x0000_0000.
